gaplus_spr_scan: RTL and testbench

Per-line sprite list scanner on the video side of the sprite attribute RAM. It reads the 64-entry sprite table through the read-only port of a 2048-byte video DPRAM while the CPU owns the write port. For each requested scanline it finds the sprites covering that line and hands them one at a time, over a valid/ready handshake, to the sprite line renderer.

---
 rtl/gaplus_spr_scan_if.sv | 30 +++
 rtl/gaplus_spr_scan.sv | 195 +++++++++++++++++++
 tb/tb_gaplus_spr_scan.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gaplus_spr_scan_if.sv
// Sprite scanner bus: scan control, sprite RAM read port
// and the valid/ready entry stream to the line renderer.
interface gaplus_spr_scan_if;
  logic        START;
  logic [7:0]  LINE;
  logic [10:0] ADRS;
  logic [7:0]  DIN;
  logic        OVALID;
  logic        OREADY;
  logic [5:0]  OIDX;
  logic [7:0]  OCODE;
  logic [8:0]  OX;
  logic [4:0]  OROW;
  logic [7:0]  OATTR;
  logic        BUSY;
  logic        DONE;
  logic        OVF;

  modport master (
    input  START, LINE, DIN, OREADY,
    output ADRS, OVALID, OIDX, OCODE, OX,
    output OROW, OATTR, BUSY, DONE, OVF
  );

  modport slave (
    output START, LINE, DIN, OREADY,
    input  ADRS, OVALID, OIDX, OCODE, OX,
    input  OROW, OATTR, BUSY, DONE, OVF
  );
endinterface

// File: rtl/gaplus_spr_scan.sv
// Per-line sprite list scanner: walks the 64-entry sprite
// table and streams the sprites covering a scanline.
module gaplus_spr_scan #(
  parameter logic [2:0] BASE   = 3'd7,
  parameter int         MAXHIT = 8
) (
  input logic            CLK,
  input logic            RESET,
  gaplus_spr_scan_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_RY, S_RA, S_CK,
    S_RC, S_RX, S_WAIT, S_FIN
  } state_t;

  localparam logic [6:0] MAXC = 7'(MAXHIT);

  state_t      state_q, state_d;
  logic [7:0]  line_q, line_d;
  logic [5:0]  idx_q, idx_d;
  logic [6:0]  cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  y_q, y_d;
  logic [7:0]  attr_q, attr_d;
  logic [4:0]  row_q, row_d;
  logic [7:0]  code_q, code_d;
  logic        ovalid_q, ovalid_d;
  logic [5:0]  oidx_q, oidx_d;
  logic [7:0]  ocode_q, ocode_d;
  logic [8:0]  ox_q, ox_d;
  logic [4:0]  orow_q, orow_d;
  logic [7:0]  oattr_q, oattr_d;

  logic [7:0]  diff;
  logic        tall;
  logic        hit;
  logic [4:0]  raw;
  logic [4:0]  row_c;
  logic        last;

  // Hit test and row within sprite, using attr on DIN in CK
  always_comb begin
    diff  = line_q - y_q;
    tall  = bus.DIN[1];
    hit   = !bus.DIN[7] &&
            (tall ? (diff < 8'd32) : (diff < 8'd16));
    raw   = tall ? diff[4:0] : {1'b0, diff[3:0]};
    row_c = raw;
    if (bus.DIN[3]) begin
      row_c = tall ? ~raw : {1'b0, ~raw[3:0]};
    end
    last  = (idx_q == 6'd63);
  end

  // Next-state and datapath updates; START overrides all
  always_comb begin
    state_d  = state_q;
    line_d   = line_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    y_d      = y_q;
    attr_d   = attr_q;
    row_d    = row_q;
    code_d   = code_q;
    ovalid_d = ovalid_q;
    oidx_d   = oidx_q;
    ocode_d  = ocode_q;
    ox_d     = ox_q;
    orow_d   = orow_q;
    oattr_d  = oattr_q;
    unique case (state_q)
      S_IDLE: ;
      S_RY: state_d = S_RA;
      S_RA: begin
        y_d     = bus.DIN;
        state_d = S_CK;
      end
      S_CK: begin
        attr_d = bus.DIN;
        row_d  = row_c;
        if (hit) begin
          if (cnt_q == MAXC) begin
            ovf_d   = 1'b1;
            state_d = S_FIN;
          end else begin
            state_d = S_RC;
          end
        end else if (last) begin
          state_d = S_FIN;
        end else begin
          idx_d   = idx_q + 6'd1;
          state_d = S_RY;
        end
      end
      S_RC: begin
        code_d  = bus.DIN;
        state_d = S_RX;
      end
      S_RX: begin
        oidx_d   = idx_q;
        ocode_d  = code_q;
        ox_d     = {attr_q[0], bus.DIN};
        orow_d   = row_q;
        oattr_d  = attr_q;
        ovalid_d = 1'b1;
        cnt_d    = cnt_q + 7'd1;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (ovalid_q && bus.OREADY) begin
          ovalid_d = 1'b0;
          if (last) begin
            state_d = S_FIN;
          end else begin
            idx_d   = idx_q + 6'd1;
            state_d = S_RY;
          end
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.START) begin
      line_d   = bus.LINE;
      idx_d    = 6'd0;
      cnt_d    = 7'd0;
      ovf_d    = 1'b0;
      ovalid_d = 1'b0;
      state_d  = S_RY;
    end
  end

  // RAM address: byte k of the current entry per state
  always_comb begin
    bus.ADRS = {BASE, idx_q, 2'd0};
    unique case (state_q)
      S_IDLE, S_FIN: bus.ADRS = {BASE, 8'h00};
      S_RY:   bus.ADRS = {BASE, idx_q, 2'd2};
      S_RA:   bus.ADRS = {BASE, idx_q, 2'd3};
      S_RC:   bus.ADRS = {BASE, idx_q, 2'd1};
      default: bus.ADRS = {BASE, idx_q, 2'd0};
    endcase
  end

  // State and datapath registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      line_q   <= 8'd0;
      idx_q    <= 6'd0;
      cnt_q    <= 7'd0;
      ovf_q    <= 1'b0;
      y_q      <= 8'd0;
      attr_q   <= 8'd0;
      row_q    <= 5'd0;
      code_q   <= 8'd0;
      ovalid_q <= 1'b0;
      oidx_q   <= 6'd0;
      ocode_q  <= 8'd0;
      ox_q     <= 9'd0;
      orow_q   <= 5'd0;
      oattr_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      line_q   <= line_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      y_q      <= y_d;
      attr_q   <= attr_d;
      row_q    <= row_d;
      code_q   <= code_d;
      ovalid_q <= ovalid_d;
      oidx_q   <= oidx_d;
      ocode_q  <= ocode_d;
      ox_q     <= ox_d;
      orow_q   <= orow_d;
      oattr_q  <= oattr_d;
    end
  end

  assign bus.OVALID = ovalid_q;
  assign bus.OIDX   = oidx_q;
  assign bus.OCODE  = ocode_q;
  assign bus.OX     = ox_q;
  assign bus.OROW   = orow_q;
  assign bus.OATTR  = oattr_q;
  assign bus.OVF    = ovf_q;
  assign bus.DONE   = (state_q == S_FIN);
  assign bus.BUSY   = (state_q != S_IDLE) &&
                      (state_q != S_FIN);

endmodule

// File: tb/tb_gaplus_spr_scan.sv
// Directed bench for gaplus_spr_scan with a registered
// sprite RAM model and hand-computed expectations.
module tb_gaplus_spr_scan;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   k_rel  = 0;

  logic [7:0] mem [0:2047];

  gaplus_spr_scan_if bus();

  gaplus_spr_scan #(.BASE(3'd7), .MAXHIT(8)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.DIN <= mem[bus.ADRS];

  int         done_at, n_ent, ndone;
  logic       busy_first, busy_done, ovf_done;
  logic [5:0] e_idx  [64];
  logic [7:0] e_code [64];
  logic [8:0] e_x    [64];
  logic [4:0] e_row  [64];
  logic [7:0] e_attr [64];
  int         e_k    [64];
  logic [46:0] snap;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    k_rel++;
  endtask

  task automatic set_spr(input int n, input logic [7:0] c,
                         input logic [7:0] x,
                         input logic [7:0] y,
                         input logic [7:0] a);
    mem[11'h700 + n*4 + 0] = c;
    mem[11'h700 + n*4 + 1] = x;
    mem[11'h700 + n*4 + 2] = y;
    mem[11'h700 + n*4 + 3] = a;
  endtask

  // Called at a negedge; START is sampled at the next posedge
  // (cycle t), return is at the negedge of cycle t+1.
  task automatic start_scan(input logic [7:0] l);
    bus.START = 1'b1;
    bus.LINE  = l;
    @(negedge clk);
    bus.START = 1'b0;
    k_rel = 1;
  endtask

  task automatic run_scan(input int limit);
    done_at    = -1;
    n_ent      = 0;
    ndone      = 0;
    busy_done  = 1'bx;
    ovf_done   = 1'bx;
    busy_first = bus.BUSY;
    while (k_rel <= limit) begin
      if (bus.OVALID && bus.OREADY && n_ent < 64) begin
        e_idx[n_ent]  = bus.OIDX;
        e_code[n_ent] = bus.OCODE;
        e_x[n_ent]    = bus.OX;
        e_row[n_ent]  = bus.OROW;
        e_attr[n_ent] = bus.OATTR;
        e_k[n_ent]    = k_rel;
        n_ent++;
      end
      if (bus.DONE) begin
        ndone++;
        if (done_at < 0) begin
          done_at   = k_rel;
          busy_done = bus.BUSY;
          ovf_done  = bus.OVF;
        end
      end
      if (done_at >= 0 && k_rel >= done_at + 3) break;
      step();
    end
  endtask

  task automatic wait_valid(input int limit);
    while (!bus.OVALID && k_rel < limit) step();
  endtask

  function automatic logic [46:0] fields();
    return {bus.OIDX, bus.OCODE, bus.OX, bus.OROW,
            bus.OATTR, bus.ADRS};
  endfunction

  initial begin
    rst       = 1'b1;
    bus.START = 1'b0;
    bus.LINE  = 8'd0;
    bus.OREADY = 1'b0;
    for (int n = 0; n < 64; n++) set_spr(n, 0, 0, 0, 8'h80);
    repeat (3) @(negedge clk);

    chk("rst_flags",
        {bus.OVALID, bus.BUSY, bus.DONE, bus.OVF}, 0);
    chk("rst_adrs", bus.ADRS, 11'h700);
    chk("rst_fields", {bus.OIDX, bus.OCODE, bus.OX,
                       bus.OROW, bus.OATTR}, 0);
    rst = 1'b0;
    @(negedge clk);

    // all disabled
    bus.OREADY = 1'b1;
    start_scan(8'h40);
    run_scan(400);
    chk("dis_done_at", done_at, 193);
    chk("dis_entries", n_ent, 0);
    chk("dis_ndone", ndone, 1);
    chk("dis_busy_t1", busy_first, 1);
    chk("dis_busy_done", busy_done, 0);
    chk("dis_ovf", ovf_done, 0);

    // single 16-line sprite
    set_spr(5, 8'h12, 8'h80, 8'h30, 8'h00);
    start_scan(8'h3F);
    run_scan(400);
    chk("s5_entries", n_ent, 1);
    chk("s5_idx", e_idx[0], 5);
    chk("s5_code", e_code[0], 8'h12);
    chk("s5_x", e_x[0], 9'h080);
    chk("s5_row", e_row[0], 15);
    chk("s5_attr", e_attr[0], 8'h00);
    chk("s5_k", e_k[0], 21);
    chk("s5_done_at", done_at, 196);
    start_scan(8'h40);
    run_scan(400);
    chk("s5_miss_entries", n_ent, 0);
    chk("s5_miss_done_at", done_at, 193);

    // tall, flipped, X8, Y wrap
    set_spr(5, 8'h12, 8'h80, 8'h30, 8'h80);
    set_spr(9, 8'h55, 8'h10, 8'hFA, 8'h0B);
    start_scan(8'h04);
    run_scan(400);
    chk("s9_entries", n_ent, 1);
    chk("s9_idx", e_idx[0], 9);
    chk("s9_code", e_code[0], 8'h55);
    chk("s9_x", e_x[0], 9'h110);
    chk("s9_row", e_row[0], 21);
    chk("s9_attr", e_attr[0], 8'h0B);

    // ten covering sprites, limit 8
    set_spr(9, 8'h55, 8'h10, 8'hFA, 8'h80);
    for (int i = 10; i < 20; i++)
      set_spr(i, 8'(i), 8'(i), 8'h20, 8'h00);
    start_scan(8'h25);
    run_scan(400);
    chk("ovf_entries", n_ent, 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("ovf_idx%0d", i), e_idx[i], 10 + i);
    chk("ovf_flag", ovf_done, 1);
    chk("ovf_done_at", done_at, 82);
    chk("ovf_held", bus.OVF, 1);

    // exactly eight covering sprites
    set_spr(18, 0, 0, 0, 8'h80);
    set_spr(19, 0, 0, 0, 8'h80);
    start_scan(8'h25);
    chk("ovf_cleared", bus.OVF, 0);
    run_scan(400);
    chk("eight_entries", n_ent, 8);
    chk("eight_last_idx", e_idx[7], 17);
    chk("eight_ovf", ovf_done, 0);
    chk("eight_done_at", done_at, 217);

    // stall on the first hit
    for (int i = 10; i < 18; i++) set_spr(i, 0, 0, 0, 8'h80);
    set_spr(5, 8'h12, 8'h80, 8'h30, 8'h00);
    bus.OREADY = 1'b0;
    start_scan(8'h3F);
    wait_valid(300);
    chk("stall_valid_k", k_rel, 21);
    snap = fields();
    for (int j = 0; j < 5; j++) begin
      step();
      chk($sformatf("stall_hold%0d", j),
          {bus.OVALID, fields()}, {1'b1, snap});
    end
    bus.OREADY = 1'b1;
    run_scan(500);
    chk("stall_entries", n_ent, 1);
    chk("stall_idx", e_idx[0], 5);
    chk("stall_k", e_k[0], 26);
    chk("stall_done_at", done_at, 201);

    // restart while in WAIT
    set_spr(20, 8'h77, 8'h33, 8'h40, 8'h00);
    bus.OREADY = 1'b0;
    start_scan(8'h3F);
    wait_valid(300);
    chk("rw_valid_k", k_rel, 21);
    start_scan(8'h41);
    chk("rw_valid_drop", {bus.OVALID, bus.BUSY}, 2'b01);
    bus.OREADY = 1'b1;
    run_scan(400);
    chk("rw_entries", n_ent, 1);
    chk("rw_idx", e_idx[0], 20);
    chk("rw_code", e_code[0], 8'h77);
    chk("rw_row", e_row[0], 1);
    chk("rw_ndone", ndone, 1);
    chk("rw_done_at", done_at, 196);

    // restart while in RA
    start_scan(8'h3F);
    step();
    start_scan(8'h41);
    run_scan(400);
    chk("ra_entries", n_ent, 1);
    chk("ra_idx", e_idx[0], 20);
    chk("ra_x", e_x[0], 9'h033);
    chk("ra_ndone", ndone, 1);
    chk("ra_done_at", done_at, 196);

    // reset mid-scan
    bus.OREADY = 1'b0;
    start_scan(8'h3F);
    wait_valid(300);
    chk("rs_valid", bus.OVALID, 1);
    rst = 1'b1;
    step();
    chk("rs_flags",
        {bus.OVALID, bus.BUSY, bus.DONE, bus.OVF}, 0);
    chk("rs_adrs", bus.ADRS, 11'h700);
    chk("rs_fields", {bus.OIDX, bus.OCODE, bus.OX,
                      bus.OROW, bus.OATTR}, 0);
    rst = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
